// File: rtl/line_clear_if.sv
// Handshake and row-port bundle between the line-clear controller, the game FSM
// and the board row array.
interface line_clear_if #(
    parameter int WIDTH = 8,
    parameter int YSIZE = 3,
    parameter int CNTW  = 8
);
    logic             start;
    logic             clearTotal;
    logic [WIDTH-1:0] rowData;
    logic [YSIZE-1:0] rowSel;
    logic [YSIZE-1:0] destroyRow;
    logic             shiftEn;
    logic             busy;
    logic             done;
    logic [YSIZE:0]   linesCleared;
    logic [CNTW-1:0]  totalLines;

    modport master (
        output start, clearTotal, rowData,
        input  rowSel, destroyRow, shiftEn, busy, done, linesCleared, totalLines
    );

    modport slave (
        input  start, clearTotal, rowData,
        output rowSel, destroyRow, shiftEn, busy, done, linesCleared, totalLines
    );
endinterface

// File: rtl/line_clear_ctrl.sv
// Row-collapse sequencer: scans board rows bottom-up, strobes a one-row collapse for
// every full row, and reports per-pass and saturating running line counts.
module line_clear_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int YSIZE  = 3,
    parameter int CNTW   = 8
) (
    input logic       clk,
    input logic       rst_n,
    line_clear_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [YSIZE-1:0] LAST_ROW  = YSIZE'(HEIGHT - 1);
    localparam logic [YSIZE:0]   ALL_ROWS  = (YSIZE + 1)'(HEIGHT);
    localparam logic [YSIZE-1:0] ROW_ONE   = YSIZE'(1);
    localparam logic [YSIZE:0]   LINE_ONE  = (YSIZE + 1)'(1);
    localparam logic [CNTW-1:0]  TOTAL_ONE = CNTW'(1);
    localparam logic [CNTW-1:0]  TOTAL_MAX = {CNTW{1'b1}};

    state_t           state_r;
    logic [YSIZE-1:0] row_sel_r;
    logic [YSIZE-1:0] destroy_row_r;
    logic [YSIZE:0]   lines_r;
    logic [CNTW-1:0]  total_r;
    logic             shift_en_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] row_data_s;
    logic             row_full_s;

    assign row_data_s = bus.rowData;
    assign row_full_s = &row_data_s;

    // Pass sequencer; every output is a register updated on the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            row_sel_r     <= '0;
            destroy_row_r <= '0;
            lines_r       <= '0;
            total_r       <= '0;
            shift_en_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    shift_en_r <= 1'b0;
                    done_r     <= 1'b0;
                    if (bus.clearTotal) begin
                        total_r <= '0;
                    end else begin
                        total_r <= total_r;
                    end
                    if (bus.start) begin
                        row_sel_r <= '0;
                        lines_r   <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= SCAN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (row_full_s) begin
                        destroy_row_r <= row_sel_r;
                        shift_en_r    <= 1'b1;
                        state_r       <= SHIFT;
                    end else if (row_sel_r == LAST_ROW) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        row_sel_r <= row_sel_r + ROW_ONE;
                        state_r   <= SCAN;
                    end
                end
                SHIFT: begin
                    shift_en_r <= 1'b0;
                    lines_r    <= lines_r + LINE_ONE;
                    if (total_r == TOTAL_MAX) begin
                        total_r <= TOTAL_MAX;
                    end else begin
                        total_r <= total_r + TOTAL_ONE;
                    end
                    state_r <= SETTLE;
                end
                SETTLE: begin
                    // The row above has dropped into row_sel_r, so it is rescanned as-is.
                    if (lines_r == ALL_ROWS) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= SCAN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    shift_en_r <= 1'b0;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rowSel       = row_sel_r;
    assign bus.destroyRow   = destroy_row_r;
    assign bus.shiftEn      = shift_en_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.linesCleared = lines_r;
    assign bus.totalLines   = total_r;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: emulates the board row array, predicts each
// pass from the full-row pattern and checks the monitor's observations against it.
module tb_line_clear_ctrl;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam int YSIZE  = 3;
    localparam int CNTW   = 8;
    localparam int TMAX   = (1 << CNTW) - 1;

    typedef struct packed {
        int clears;
        int total;
        int done_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_clear_if #(.WIDTH(WIDTH), .YSIZE(YSIZE), .CNTW(CNTW)) bus ();

    line_clear_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .YSIZE(YSIZE), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] board     [HEIGHT];
    logic [WIDTH-1:0] new_board [HEIGHT];
    logic             load_req = 1'b0;
    logic             stuck    = 1'b0;
    int               cyc      = 0;

    exp_t exp_q[$];
    int   exp_destroy[$];
    int   pass_pulses = 0;
    int   done_cnt    = 0;
    int   total_model = 0;
    int   n_checks    = 0;
    int   n_pass      = 0;

    assign bus.rowData = stuck ? {WIDTH{1'b1}} : board[bus.rowSel];

    always @(posedge clk) cyc <= cyc + 1;

    // Board row array: bulk load from the driver, otherwise collapse on shiftEn.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < HEIGHT; i++) board[i] <= new_board[i];
        end else if (bus.shiftEn) begin
            for (int i = 0; i < HEIGHT - 1; i++)
                if (i >= int'(bus.destroyRow)) board[i] <= board[i + 1];
            board[HEIGHT - 1] <= '0;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compares every collapse strobe and every end-of-pass report.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.shiftEn) begin
                pass_pulses++;
                if (exp_destroy.size() == 0) check("destroy_unexpected", 1, 0);
                else check("destroyRow", int'(bus.destroyRow), exp_destroy.pop_front());
            end
            if (bus.done) begin
                exp_t e;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("shift_pulses", pass_pulses, e.clears);
                    check("linesCleared", int'(bus.linesCleared), e.clears);
                    check("totalLines", int'(bus.totalLines), e.total);
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_at_done", int'(bus.busy), 1);
                end
                pass_pulses = 0;
            end
        end
    end

    // Reference: walk rows bottom-up; a full row is removed and the same index looked at again.
    task automatic predict(input logic [HEIGHT-1:0] full_mask, input bit stk, output int clears,
                           output int edges);
        bit full[HEIGHT];
        int r = 0;
        int scans = 0;
        clears = 0;
        for (int i = 0; i < HEIGHT; i++) full[i] = stk || full_mask[i];
        while (1) begin
            scans++;
            if (full[r]) begin
                exp_destroy.push_back(r);
                clears++;
                if (!stk) begin
                    for (int j = r; j < HEIGHT - 1; j++) full[j] = full[j + 1];
                    full[HEIGHT - 1] = 1'b0;
                end
                if (clears == HEIGHT) break;
            end else if (r == HEIGHT - 1) begin
                break;
            end else begin
                r++;
            end
        end
        edges = scans + 2 * clears;
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic load_board(input logic [HEIGHT-1:0] full_mask, input bit stk);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < HEIGHT; i++) begin
            v = WIDTH'($urandom);
            v[$urandom_range(WIDTH - 1, 0)] = 1'b0;
            new_board[i] = full_mask[i] ? {WIDTH{1'b1}} : v;
        end
        stuck    = stk;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic issue_start(input logic [HEIGHT-1:0] full_mask, input bit stk);
        int clears, edges;
        exp_t e;
        predict(full_mask, stk, clears, edges);
        total_model = (total_model + clears > TMAX) ? TMAX : total_model + clears;
        e.clears   = clears;
        e.total    = total_model;
        e.done_cyc = cyc + 1 + edges;
        exp_q.push_back(e);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_pass(input logic [HEIGHT-1:0] full_mask, input bit stk, input bit poke);
        int d0 = done_cnt;
        int t = 0;
        load_board(full_mask, stk);
        issue_start(full_mask, stk);
        if (poke) begin
            repeat (2) tick();
            bus.start      = 1'b1;
            bus.clearTotal = 1'b1;
            tick();
            bus.start      = 1'b0;
            bus.clearTotal = 1'b0;
        end
        while (done_cnt == d0 && t < 100) begin
            tick();
            t++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        tick();
        check("busy_after_done", int'(bus.busy), 0);
        stuck = 1'b0;
        if (poke) begin
            repeat (2) tick();
            check("start_not_queued", int'(bus.busy), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_shiftEn"}, int'(bus.shiftEn), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_rowSel"}, int'(bus.rowSel), 0);
        check({tag, "_destroyRow"}, int'(bus.destroyRow), 0);
        check({tag, "_linesCleared"}, int'(bus.linesCleared), 0);
        check({tag, "_totalLines"}, int'(bus.totalLines), 0);
    endtask

    initial begin
        int t;
        bus.start      = 1'b0;
        bus.clearTotal = 1'b0;
        for (int i = 0; i < HEIGHT; i++) new_board[i] = '0;
        #1;
        check_all_zero("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_pass(8'b0000_0000, 1'b0, 1'b0);
        run_pass(8'b0000_0001, 1'b0, 1'b0);
        run_pass(8'b0010_1100, 1'b0, 1'b0);
        run_pass(8'b0000_0000, 1'b1, 1'b0);
        run_pass(8'b1000_0000, 1'b0, 1'b0);
        run_pass(8'b1111_1111, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++)
            run_pass(HEIGHT'($urandom & $urandom), 1'b0, (k % 3) == 0);

        bus.clearTotal = 1'b1;
        tick();
        bus.clearTotal = 1'b0;
        total_model = 0;
        check("clearTotal_idle", int'(bus.totalLines), 0);

        for (int k = 0; k < 31; k++) run_pass(8'b0000_0000, 1'b1, 1'b0);
        run_pass(8'b0011_1111, 1'b0, 1'b0);
        check("total_254", int'(bus.totalLines), 254);
        run_pass(8'b0000_0111, 1'b0, 1'b1);
        check("total_saturated", int'(bus.totalLines), TMAX);

        load_board(8'b0000_1000, 1'b0);
        issue_start(8'b0000_1000, 1'b0);
        t = 0;
        while (!bus.shiftEn && t < 50) begin
            tick();
            t++;
        end
        check("reach_shift", int'(bus.shiftEn), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        exp_destroy.delete();
        pass_pulses = 0;
        total_model = 0;
        repeat (3) begin
            tick();
            check("no_shift_in_reset", int'(bus.shiftEn), 0);
        end
        rst_n = 1'b1;
        tick();
        run_pass(8'b0100_0010, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
